chromosome_error_accumulator: RTL and testbench
===============================================

CHROMOSOME_ERROR_ACCUMULATOR -- requirements
Module: chromosome_error_accumulator

Interface
REQ-001 The block SHALL have parameter N_OUTPUTS, default 8, meaning the number of chromosome output bits scored (1..32).
REQ-002 The block SHALL have parameter SEQ_DEPTH, default 16, meaning the number of expected-sequence entries (2..256).
REQ-003 The block SHALL have parameter IDX_W, default 4, meaning the sequence index width, with IDX_W = clog2(SEQ_DEPTH).
REQ-004 The block SHALL have parameter SUM_W, default 32, meaning the per-channel error counter width.
REQ-005 The block SHALL have parameter CYCLES_TO_IGNORE, default 0, meaning the number of leading valid samples discarded per run.
REQ-006 The block SHALL have parameter TOT_W, default SUM_W+clog2(N_OUTPUTS), meaning the total-error width.
REQ-007 The block SHALL have a port iClock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 The block SHALL have a port iReset, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have a port iStart, input, 1 bit: a pulse that begins a new run.
REQ-010 The block SHALL have a port iStop, input, 1 bit: a pulse that ends the current run.
REQ-011 The block SHALL have a port iClear, input, 1 bit: returns the block from HOLD to IDLE and zeroes the results.
REQ-012 The block SHALL have a port iSampleValid, input, 1 bit: the current sample is to be scored.
REQ-013 The block SHALL have a port iCurrentSequence, input, IDX_W bits: the expected-sequence entry index for this sample.
REQ-014 The block SHALL have a port iExpectedSequence, input, SEQ_DEPTH x N_OUTPUTS bits: the expected output table.
REQ-015 The block SHALL have a port iChromosomeOutput, input, N_OUTPUTS bits: the circuit-under-evaluation outputs.
REQ-016 The block SHALL have a port iOutputMask, input, N_OUTPUTS bits: when a bit is 1, that channel is scored.
REQ-017 The block SHALL have a port oErrorSums, output, N_OUTPUTS x SUM_W bits: the per-channel mismatch counts.
REQ-018 The block SHALL have a port oTotalError, output, TOT_W bits: the sum of all scored mismatches.
REQ-019 The block SHALL have a port oBusy, output, 1 bit: high in the IGNORE and ACCUM states.
REQ-020 The block SHALL have a port oDone, output, 1 bit: a one-cycle pulse on entry to HOLD.
REQ-021 The block SHALL have a port oSaturated, output, 1 bit: a sticky flag set when any counter clipped during the run.
REQ-022 The block SHALL have a port oIndexError, output, 1 bit: a sticky flag set when a valid sample arrived with iCurrentSequence >= SEQ_DEPTH.

Function
REQ-023 The block SHALL have FSM states IDLE, IGNORE, ACCUM and HOLD, and all outputs SHALL be registered.
REQ-024 When iStart is high in any state, the block SHALL zero the sums, total and sticky flags, clear the ignore counter, and go to IGNORE if CYCLES_TO_IGNORE>0, else to ACCUM; this SHALL take effect on the next cycle.
REQ-025 In IGNORE, the block SHALL count valid samples only, and after the CYCLES_TO_IGNORE-th valid sample it SHALL go to ACCUM; no accumulation SHALL occur in IGNORE.
REQ-026 In ACCUM, for each valid sample with an in-range index, the block SHALL compute per channel c: err_c = (iChromosomeOutput[c] ^ iExpectedSequence[idx][c]) & iOutputMask[c].
REQ-027 In ACCUM, the block SHALL perform oErrorSums[c] += err_c, saturating at 2^SUM_W-1; a clip SHALL set oSaturated.
REQ-028 In ACCUM, the block SHALL perform oTotalError += popcount(err), saturating at 2^TOT_W-1; a clip SHALL set oSaturated.
REQ-029 Results SHALL be visible one cycle after the sample (latency 1).
REQ-030 A valid sample with idx >= SEQ_DEPTH SHALL not be accumulated and SHALL set oIndexError; in IGNORE it SHALL still count toward the ignore count.
REQ-031 iStop in IGNORE or ACCUM SHALL cause a transition to HOLD, with oDone high for exactly the first HOLD cycle.
REQ-032 On simultaneous iStop and iSampleValid in ACCUM, the sample SHALL be accumulated before HOLD.
REQ-033 iStop in IDLE or HOLD SHALL be ignored.
REQ-034 iStart SHALL take priority over iStop and iClear in the same cycle.
REQ-035 In HOLD, all results SHALL be frozen regardless of iSampleValid or the mask.
REQ-036 iClear in HOLD or IDLE SHALL zero the results and flags and set the state to IDLE; iClear in IGNORE or ACCUM SHALL be ignored.
REQ-037 A change of iOutputMask mid-run SHALL apply from the next valid sample and SHALL not alter past counts.

Reset
REQ-038 When iReset is high at a clock edge, the block SHALL set the state to IDLE and set oErrorSums, oTotalError, oBusy, oDone, oSaturated and oIndexError to 0.
REQ-039 iReset SHALL override all other inputs, including a mid-run reset, and the block SHALL discard partial results.

Verification
REQ-040 Basic scoring (defaults, ignore=2): iStart; 2 valid samples ignored; 4 valid samples with output 0xFF, expected 0x0F, mask 0xFF; iStop -> sums[7:4]=4 and sums[3:0]=0, total=16, oDone pulses once.
REQ-041 Masking: mask 0x01 with output xor expected = 0xFF for 3 samples -> sums[0]=3, all others 0, total=3.
REQ-042 Saturation: SUM_W=2, 5 mismatching samples on channel 0 -> sums[0]=3, oSaturated=1.
REQ-043 Boundary: SEQ_DEPTH=12, valid sample with idx=13 in ACCUM -> no count change, oIndexError=1.
REQ-044 Stop and valid in the same cycle: stop coincident with a mismatching sample -> count includes that sample; later valid samples in HOLD leave counts unchanged.
REQ-045 Reset and restart: iReset mid-ACCUM -> all outputs 0 and state IDLE; iStart during HOLD -> results zero and oBusy=1 on the next cycle.

Source files
------------

// File: rtl/chromosome_error_accumulator.sv
// ---------------------------------------------------------------------------
// chromosome_error_accumulator
//
// Scores a chromosome (candidate circuit) against an expected output table.
// For each valid sample, the chromosome's outputs are XORed with the indexed
// expected row. The result is then ANDed with the channel mask. Each set bit
// adds one to that channel's error counter and to the total error. Counters
// saturate and raise a sticky flag. A run is framed by iStart / iStop. The
// first CYCLES_TO_IGNORE valid samples of a run are discarded. Results are
// frozen in HOLD until iClear or the next iStart.
//
// Ports
//   iClock             rising-edge clock
//   iReset             synchronous active-high reset
//   iStart             pulse: zero results and begin a run (highest priority)
//   iStop              pulse: end the run (IGNORE/ACCUM only)
//   iClear             pulse: zero results, go to IDLE (IDLE/HOLD only)
//   iSampleValid       current sample is to be scored
//   iCurrentSequence   expected-table row index for this sample
//   iExpectedSequence  flat table, row r at [r*N_OUTPUTS +: N_OUTPUTS]
//   iChromosomeOutput  outputs of the circuit being evaluated
//   iOutputMask        1 = channel is scored
//   oErrorSums         flat per-channel counts, channel c at [c*SUM_W +: SUM_W]
//   oTotalError        sum of all scored mismatches
//   oBusy              run in progress (IGNORE or ACCUM)
//   oDone              one-cycle pulse on entry to HOLD
//   oSaturated         sticky: some counter clipped during this run
//   oIndexError        sticky: valid sample with out-of-range index
//   oDbgState          current FSM state (0 IDLE, 1 IGNORE, 2 ACCUM, 3 HOLD)
//
// Handshake: there is no back-pressure. A sample is consumed in every cycle
// where iSampleValid is high. Results appear one cycle later.
// ---------------------------------------------------------------------------
module chromosome_error_accumulator #(
  parameter int N_OUTPUTS        = 8,
  parameter int SEQ_DEPTH        = 16,
  parameter int IDX_W            = 4,
  parameter int SUM_W            = 32,
  parameter int CYCLES_TO_IGNORE = 0,
  parameter int TOT_W            = SUM_W + $clog2(N_OUTPUTS)
) (
  input  logic                           iClock,
  input  logic                           iReset,
  input  logic                           iStart,
  input  logic                           iStop,
  input  logic                           iClear,
  input  logic                           iSampleValid,
  input  logic [IDX_W-1:0]               iCurrentSequence,
  input  logic [SEQ_DEPTH*N_OUTPUTS-1:0] iExpectedSequence,
  input  logic [N_OUTPUTS-1:0]           iChromosomeOutput,
  input  logic [N_OUTPUTS-1:0]           iOutputMask,
  output logic [N_OUTPUTS*SUM_W-1:0]     oErrorSums,
  output logic [TOT_W-1:0]               oTotalError,
  output logic                           oBusy,
  output logic                           oDone,
  output logic                           oSaturated,
  output logic                           oIndexError,
  output logic [1:0]                     oDbgState
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IGNORE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int PC_W = $clog2(N_OUTPUTS + 1);
  localparam logic [SUM_W-1:0] SUM_MAX  = {SUM_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};
  // With CYCLES_TO_IGNORE == 0 this value is never compared against.
  localparam logic [31:0]      IGN_LAST = 32'(CYCLES_TO_IGNORE - 1);

  state_t                       r_state;
  state_t                       w_state_next;
  logic [N_OUTPUTS*SUM_W-1:0]   r_sums;
  logic [TOT_W-1:0]             r_total;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_sat;
  logic                         r_idx_err;
  logic [31:0]                  r_ign_cnt;

  logic                         w_zero;
  logic                         w_in_range;
  logic                         w_run;
  logic                         w_accum;
  logic                         w_idx_err;
  logic                         w_ign_inc;
  logic [N_OUTPUTS-1:0]         w_row;
  logic [N_OUTPUTS-1:0]         w_err;
  logic [PC_W-1:0]              w_pop;
  logic [N_OUTPUTS*SUM_W-1:0]   w_sums_next;
  logic [TOT_W:0]               w_total_wide;
  logic [TOT_W-1:0]             w_total_next;
  logic                         w_clip;

  // Sample qualification. iStart wins over everything, so nothing is
  // scored in the cycle where a run is (re)started.
  assign w_in_range = (int'(iCurrentSequence) < SEQ_DEPTH);
  assign w_run      = (r_state == ST_IGNORE) || (r_state == ST_ACCUM);
  assign w_accum    = !iStart && (r_state == ST_ACCUM) && iSampleValid && w_in_range;
  assign w_idx_err  = !iStart && w_run && iSampleValid && !w_in_range;
  // Out-of-range samples still count toward the ignore window.
  assign w_ign_inc  = !iStart && (r_state == ST_IGNORE) && iSampleValid;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_zero       = 1'b0;
    if (iStart) begin
      w_zero = 1'b1;
      if (CYCLES_TO_IGNORE > 0) w_state_next = ST_IGNORE;
      else                      w_state_next = ST_ACCUM;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iClear) w_zero = 1'b1;
        end
        ST_IGNORE: begin
          if (iStop)                                       w_state_next = ST_HOLD;
          else if (iSampleValid && (r_ign_cnt == IGN_LAST)) w_state_next = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (iStop) w_state_next = ST_HOLD;
        end
        ST_HOLD: begin
          if (iClear) begin
            w_zero       = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Row lookup; the loop form keeps an out-of-range index from selecting
  // past the end of the table (such samples are never accumulated anyway).
  always_comb begin
    w_row = '0;
    for (int e = 0; e < SEQ_DEPTH; e++) begin
      if (iCurrentSequence == IDX_W'(e)) w_row = iExpectedSequence[e*N_OUTPUTS +: N_OUTPUTS];
    end
  end

  assign w_err = (iChromosomeOutput ^ w_row) & iOutputMask;

  // Saturating counter updates
  always_comb begin
    w_sums_next = r_sums;
    w_clip      = 1'b0;
    w_pop       = '0;
    for (int c = 0; c < N_OUTPUTS; c++) begin
      w_pop = w_pop + PC_W'(w_err[c]);
      if (w_err[c]) begin
        if (r_sums[c*SUM_W +: SUM_W] == SUM_MAX) w_clip = 1'b1;
        else w_sums_next[c*SUM_W +: SUM_W] = r_sums[c*SUM_W +: SUM_W] + SUM_W'(1);
      end
    end
    w_total_wide = {1'b0, r_total} + (TOT_W+1)'(w_pop);
    if (w_total_wide > {1'b0, TOT_MAX}) begin
      w_total_next = TOT_MAX;
      w_clip       = 1'b1;
    end else begin
      w_total_next = w_total_wide[TOT_W-1:0];
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state   <= ST_IDLE;
      r_sums    <= '0;
      r_total   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_idx_err <= 1'b0;
      r_ign_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_IGNORE) || (w_state_next == ST_ACCUM);
      r_done  <= (w_state_next == ST_HOLD) && (r_state != ST_HOLD);
      if (w_zero) begin
        r_sums    <= '0;
        r_total   <= '0;
        r_sat     <= 1'b0;
        r_idx_err <= 1'b0;
        r_ign_cnt <= '0;
      end else begin
        if (w_ign_inc) r_ign_cnt <= r_ign_cnt + 32'd1;
        if (w_accum) begin
          r_sums  <= w_sums_next;
          r_total <= w_total_next;
          if (w_clip) r_sat <= 1'b1;
        end
        if (w_idx_err) r_idx_err <= 1'b1;
      end
    end
  end

  assign oErrorSums  = r_sums;
  assign oTotalError = r_total;
  assign oBusy       = r_busy;
  assign oDone       = r_done;
  assign oSaturated  = r_sat;
  assign oIndexError = r_idx_err;
  assign oDbgState   = r_state;

endmodule

// File: tb/tb_chromosome_error_accumulator.sv
// ---------------------------------------------------------------------------
// tb_chromosome_error_accumulator
//
// Three instances run in lockstep on shared stimulus:
//   u_a : defaults, CYCLES_TO_IGNORE=2
//   u_b : SUM_W=2 (saturation), CYCLES_TO_IGNORE=2
//   u_c : SEQ_DEPTH=12 (index boundary), CYCLES_TO_IGNORE=2
// Every expected-table row is 0x0F. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_chromosome_error_accumulator;

  // Clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic         stop;
  logic         clr;
  logic         valid;
  logic [3:0]   idx;
  logic [127:0] exp_tab;
  logic [7:0]   cout;
  logic [7:0]   mask;

  logic [255:0] a_sums;
  logic [34:0]  a_tot;
  logic         a_busy, a_done, a_sat, a_ierr;
  logic [1:0]   a_st;

  logic [15:0]  b_sums;
  logic [4:0]   b_tot;
  logic         b_busy, b_done, b_sat, b_ierr;
  logic [1:0]   b_st;

  logic [255:0] c_sums;
  logic [34:0]  c_tot;
  logic         c_busy, c_done, c_sat, c_ierr;
  logic [1:0]   c_st;

  int n_vec  = 0;
  int n_miss = 0;

  chromosome_error_accumulator #(
    .N_OUTPUTS(8), .SEQ_DEPTH(16), .IDX_W(4), .SUM_W(32), .CYCLES_TO_IGNORE(2)
  ) u_a (
    .iClock(clk), .iReset(rst), .iStart(start), .iStop(stop), .iClear(clr),
    .iSampleValid(valid), .iCurrentSequence(idx), .iExpectedSequence(exp_tab),
    .iChromosomeOutput(cout), .iOutputMask(mask),
    .oErrorSums(a_sums), .oTotalError(a_tot), .oBusy(a_busy), .oDone(a_done),
    .oSaturated(a_sat), .oIndexError(a_ierr), .oDbgState(a_st)
  );

  chromosome_error_accumulator #(
    .N_OUTPUTS(8), .SEQ_DEPTH(16), .IDX_W(4), .SUM_W(2), .CYCLES_TO_IGNORE(2)
  ) u_b (
    .iClock(clk), .iReset(rst), .iStart(start), .iStop(stop), .iClear(clr),
    .iSampleValid(valid), .iCurrentSequence(idx), .iExpectedSequence(exp_tab),
    .iChromosomeOutput(cout), .iOutputMask(mask),
    .oErrorSums(b_sums), .oTotalError(b_tot), .oBusy(b_busy), .oDone(b_done),
    .oSaturated(b_sat), .oIndexError(b_ierr), .oDbgState(b_st)
  );

  chromosome_error_accumulator #(
    .N_OUTPUTS(8), .SEQ_DEPTH(12), .IDX_W(4), .SUM_W(32), .CYCLES_TO_IGNORE(2)
  ) u_c (
    .iClock(clk), .iReset(rst), .iStart(start), .iStop(stop), .iClear(clr),
    .iSampleValid(valid), .iCurrentSequence(idx), .iExpectedSequence(exp_tab[95:0]),
    .iChromosomeOutput(cout), .iOutputMask(mask),
    .oErrorSums(c_sums), .oTotalError(c_tot), .oBusy(c_busy), .oDone(c_done),
    .oSaturated(c_sat), .oIndexError(c_ierr), .oDbgState(c_st)
  );

  // Driver tasks: inputs change 1 time unit after the rising edge; outputs
  // are sampled at the same point, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [3:0] i, input logic [7:0] o);
    valid = 1'b1;
    idx   = i;
    cout  = o;
    tick();
    valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; valid = 1'b0;
    idx = '0; cout = '0; mask = 8'hFF;
    for (int e = 0; e < 16; e++) exp_tab[e*8 +: 8] = 8'h0F;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_sums",  a_sums[63:0], 64'd0);
    chk("rst_total", a_tot, 64'd0);
    chk("rst_busy",  a_busy, 64'd0);
    chk("rst_done",  a_done, 64'd0);
    chk("rst_sat",   a_sat, 64'd0);
    chk("rst_ierr",  a_ierr, 64'd0);
    chk("rst_state", a_st, 64'd0);

    // Basic scoring: start, two ignored samples, four scored samples
    pulse_start();
    chk("start_busy",  a_busy, 64'd1);
    chk("start_state", a_st, 64'd1);
    sample(4'd0, 8'hFF);
    sample(4'd0, 8'hFF);
    chk("ignore_total", a_tot, 64'd0);
    chk("ignore_to_accum", a_st, 64'd2);
    sample(4'd1, 8'hFF);
    chk("lat1_total", a_tot, 64'd4);
    sample(4'd2, 8'hFF);
    sample(4'd3, 8'hFF);
    sample(4'd4, 8'hFF);
    pulse_stop();
    chk("stop_state", a_st, 64'd3);
    chk("stop_done",  a_done, 64'd1);
    chk("stop_busy",  a_busy, 64'd0);
    tick();
    chk("done_once", a_done, 64'd0);
    chk("basic_ch7", a_sums[7*32 +: 32], 64'd4);
    chk("basic_ch4", a_sums[4*32 +: 32], 64'd4);
    chk("basic_ch3", a_sums[3*32 +: 32], 64'd0);
    chk("basic_ch0", a_sums[0*32 +: 32], 64'd0);
    chk("basic_total", a_tot, 64'd16);
    chk("basic_nosat", a_sat, 64'd0);
    chk("b_clip_ch7", b_sums[7*2 +: 2], 64'd3);
    chk("b_clip_sat", b_sat, 64'd1);
    chk("b_total", b_tot, 64'd16);

    // HOLD freezes results
    sample(4'd5, 8'hFF);
    sample(4'd6, 8'h00);
    chk("hold_frozen", a_tot, 64'd16);

    // iStart beats iStop and iClear in the same cycle
    start = 1'b1; stop = 1'b1; clr = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; clr = 1'b0;
    chk("restart_total", a_tot, 64'd0);
    chk("restart_state", a_st, 64'd1);
    chk("restart_b_sat", b_sat, 64'd0);

    // Masking: mask 0x01, output^expected = 0xFF
    sample(4'd0, 8'h00);
    sample(4'd0, 8'h00);
    mask = 8'h01;
    sample(4'd5, 8'hF0);
    sample(4'd5, 8'hF0);
    sample(4'd5, 8'hF0);
    chk("mask_ch0", a_sums[0*32 +: 32], 64'd3);
    chk("mask_ch1", a_sums[1*32 +: 32], 64'd0);
    chk("mask_ch7", a_sums[7*32 +: 32], 64'd0);
    chk("mask_total", a_tot, 64'd3);
    chk("b_ch0_at_max", b_sums[1:0], 64'd3);
    chk("b_nosat_at_max", b_sat, 64'd0);

    // Saturation: two more mismatches on channel 0 (five total)
    sample(4'd5, 8'hF0);
    sample(4'd5, 8'hF0);
    chk("sat_b_ch0", b_sums[1:0], 64'd3);
    chk("sat_b_flag", b_sat, 64'd1);
    chk("sat_a_ch0", a_sums[0*32 +: 32], 64'd5);

    // Mask change mid-run applies from the next sample only
    mask = 8'h02;
    sample(4'd5, 8'hF0);
    chk("maskchg_ch0", a_sums[0*32 +: 32], 64'd5);
    chk("maskchg_ch1", a_sums[1*32 +: 32], 64'd1);
    chk("maskchg_total", a_tot, 64'd6);

    // iClear ignored while running
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_in_accum_total", a_tot, 64'd6);
    chk("clr_in_accum_state", a_st, 64'd2);

    // Index boundary: idx 13 is in range for u_a, out of range for u_c
    mask = 8'hFF;
    sample(4'd13, 8'hF0);
    chk("idx13_a_total", a_tot, 64'd14);
    chk("idx13_a_ierr", a_ierr, 64'd0);
    chk("idx13_c_total", c_tot, 64'd6);
    chk("idx13_c_ch2", c_sums[2*32 +: 32], 64'd0);
    chk("idx13_c_ierr", c_ierr, 64'd1);

    // Stop coincident with a mismatching sample
    mask = 8'h01;
    valid = 1'b1; stop = 1'b1; idx = 4'd0; cout = 8'hF0;
    tick();
    valid = 1'b0; stop = 1'b0;
    chk("stopvalid_ch0", a_sums[0*32 +: 32], 64'd7);
    chk("stopvalid_total", a_tot, 64'd15);
    chk("stopvalid_done", a_done, 64'd1);
    sample(4'd0, 8'hF0);
    sample(4'd1, 8'hF0);
    chk("stopvalid_hold_total", a_tot, 64'd15);
    chk("stopvalid_hold_ch0", a_sums[0*32 +: 32], 64'd7);

    // iClear in HOLD
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_state", a_st, 64'd0);
    chk("clear_total", a_tot, 64'd0);
    chk("clear_c_ierr", c_ierr, 64'd0);

    // iStop in IDLE ignored
    pulse_stop();
    chk("idle_stop_state", a_st, 64'd0);
    chk("idle_stop_done", a_done, 64'd0);

    // Reset mid-ACCUM discards partial results
    mask = 8'hFF;
    pulse_start();
    sample(4'd0, 8'h00);
    sample(4'd0, 8'h00);
    sample(4'd2, 8'hFF);
    chk("pre_reset_total", a_tot, 64'd4);
    rst = 1'b1;
    valid = 1'b1; cout = 8'hFF;
    tick();
    rst = 1'b0; valid = 1'b0;
    chk("midreset_total", a_tot, 64'd0);
    chk("midreset_ch7", a_sums[7*32 +: 32], 64'd0);
    chk("midreset_state", a_st, 64'd0);
    chk("midreset_busy", a_busy, 64'd0);

    // Out-of-range samples still count toward the ignore window
    pulse_start();
    sample(4'd13, 8'hFF);
    sample(4'd14, 8'hFF);
    chk("ign_oor_c_state", c_st, 64'd2);
    chk("ign_oor_c_ierr", c_ierr, 64'd1);
    chk("ign_oor_c_total", c_tot, 64'd0);

    // iStart during HOLD: results zero and busy on the next cycle
    sample(4'd3, 8'hFF);
    chk("run3_total", a_tot, 64'd4);
    pulse_stop();
    chk("run3_hold", a_st, 64'd3);
    pulse_start();
    chk("hold_start_total", a_tot, 64'd0);
    chk("hold_start_busy", a_busy, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
